// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the bus matrix and its slaves.
// Holds the HTRANS / HSIZE / HRESP encodings and a helper that turns a
// transfer size plus the address LSBs into a 4-lane byte mask.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte lanes touched by a transfer of the given size at address LSBs lsb.
  // Sizes above a word never reach the RAM, so they map to all lanes.
  function automatic logic [3:0] size_to_mask(input logic [2:0] size,
                                              input logic [1:0] lsb);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << lsb;
      HSIZE_HALF: mask = 4'b0011 << lsb;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_bram_bypass.sv
// Write-to-read bypass for the block-RAM controller.
// Remembers the word address, data and byte lanes of the most recent RAM
// write and overlays those lanes on RAM read data of the same word, so the
// read result is independent of the RAM's read-during-write behaviour.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears lane mask)
//   wr_addr/data    RAM write port a address and data
//   wr_mask         RAM byte write enables; register loads when non-zero
//   rd_addr         word address of the read in its data phase
//   rd_data         RAM port b read data
//   merged          rd_data with bypassed lanes substituted
module ahb_bram_bypass #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_mask,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  output logic [31:0]           merged
);

  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [31:0]           last_data_q, last_data_d;
  logic [3:0]            last_mask_q, last_mask_d;

  always_comb begin
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    last_mask_d = last_mask_q;
    if (wr_mask != 4'd0) begin
      last_addr_d = wr_addr;
      // Repeated writes to one word accumulate lanes; a new word restarts.
      last_mask_d = (wr_addr == last_addr_q) ? (last_mask_q | wr_mask) : wr_mask;
      for (int i = 0; i < 4; i++) begin
        last_data_d[8*i +: 8] = wr_mask[i] ? wr_data[8*i +: 8] : last_data_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mask_q <= 4'd0;
    end else begin
      last_mask_q <= last_mask_d;
    end
  end

  // Address and data are qualified by last_mask_q, so they need no reset.
  always_ff @(posedge clk) begin
    last_addr_q <= last_addr_d;
    last_data_q <= last_data_d;
  end

  always_comb begin
    merged = rd_data;
    for (int i = 0; i < 4; i++) begin
      if (last_mask_q[i] && (last_addr_q == rd_addr)) begin
        merged[8*i +: 8] = last_data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a 32-bit dual-port block RAM (write port a,
// read port b with registered address). Zero-wait-state reads and writes,
// two-cycle ERROR response for illegal sizes/alignments, and a write-to-read
// bypass so back-to-back write/read of one word returns the new data.
// Ports:
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   HSEL..HREADY                 AHB-Lite address/data phase inputs
//   HREADYOUT, HRESP, HRDATA     AHB-Lite slave response
//   addra, dina, wea             RAM write port a
//   addrb, doutb                 RAM read port b (doutb valid one cycle later)
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;
  logic                  write_q, write_d;

  logic        accept;
  logic        legal;
  logic        data_wr;
  logic        data_rd;
  logic [31:0] merged;

  // Burst type, upper address bits and the SEQ/NONSEQ distinction play no
  // part: every beat is decoded alone and the address wraps in the RAM.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];

  always_comb begin
    legal = 1'b1;
    if (HSIZE > HSIZE_WORD)                              legal = 1'b0;
    if ((HSIZE == HSIZE_HALF) && HADDR[0])               legal = 1'b0;
    if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))  legal = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    write_d   = write_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      ST_ERR1: begin
        // First error cycle stalls the bus so the master can cancel.
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: begin
        if (state_q == ST_ERR2) HRESP = HRESP_ERROR;
        if (accept) begin
          addr_d  = HADDR[ADDR_WIDTH+1:2];
          mask_d  = size_to_mask(HSIZE, HADDR[1:0]);
          write_d = HWRITE;
          state_d = legal ? ST_DATA : ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mask_q  <= 4'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      write_q <= write_d;
    end
  end

  assign data_wr = (state_q == ST_DATA) &&  write_q;
  assign data_rd = (state_q == ST_DATA) && !write_q;

  assign addra  = addr_q;
  assign wea    = data_wr ? mask_q : 4'd0;
  assign dina   = data_wr ? HWDATA : 32'd0;
  // RAM registers addrb itself, so the address phase drives it directly.
  assign addrb  = HADDR[ADDR_WIDTH+1:2];
  assign HRDATA = data_rd ? merged : 32'd0;

  ahb_bram_bypass #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bypass (
    .clk     (HCLK),
    .rst     (HRESET),
    .wr_addr (addra),
    .wr_data (dina),
    .wr_mask (wea),
    .rd_addr (addr_q),
    .rd_data (doutb),
    .merged  (merged)
  );

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
AHB-Lite slave that fronts the team's 32-bit dual-port block RAM (separate write port a and read port b, with a registered read address). It sits directly upstream of the RAM, between the bus-matrix slave port and the RAM.
- Converts AHB address and data phases into RAM write strobes and read addresses.
- Zero-wait-state reads and writes.
- Two-cycle ERROR response for illegal transfers.
- Write-to-read bypass, so results do not depend on the RAM's read-during-write mode.

Parameters:
ADDR_WIDTH, 14, RAM word-address width; the slave decodes HADDR[ADDR_WIDTH+1:2].

Ports:
HCLK  in  1  clock; also drives the RAM's clka.
HRESET  in  1  asynchronous, active-high reset.
HSEL  in  1  slave select.
HADDR  in  32  byte address.
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HWRITE  in  1  1=write.
HSIZE  in  3  0=byte, 1=half, 2=word; values above 2 are illegal.
HBURST  in  3  ignored; every beat is handled as a single transfer.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus-wide ready; an address phase is accepted only when high.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0=OKAY, 1=ERROR.
HRDATA  out  32  read data.
addra  out  ADDR_WIDTH  RAM write word address.
dina  out  32  RAM write data.
wea  out  4  RAM byte write enables.
addrb  out  ADDR_WIDTH  RAM read word address; the RAM registers it internally.
doutb  in  32  RAM read data, valid the cycle after addrb is sampled.

Behaviour:
- Accept condition: HSEL & HREADY & HTRANS[1].
  - BUSY and IDLE are accepted with OKAY and have no effect.
- Legality check on an accepted transfer:
  - Illegal if HSIZE > 2, or HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]≠0.
  - Byte mask: byte → 1<<A; half → 3<<A; word → 4'hF, where A = HADDR[1:0].
- State machine states: IDLE, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On a legal accept → DATA. On an illegal accept → ERR1.
  - DATA: HREADYOUT=1, HRESP=0. A new legal accept → DATA, an illegal accept → ERR1, no accept → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Unconditionally → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Decode proceeds as in IDLE.
  - An erroring transfer never asserts wea.
- Address-phase registers, loaded on accept: word address, byte mask, write flag.
- Write:
  - In the DATA cycle of a write: addra = registered word address, wea = registered mask, dina = HWDATA. All three are combinational from registered state and HWDATA.
  - The RAM commits at the end of the data phase.
  - wea = 0 in every other cycle.
- Read:
  - addrb = HADDR[ADDR_WIDTH+1:2] combinationally, every cycle.
  - The RAM samples addrb at the accept edge, so doutb is valid in the DATA cycle.
  - Read latency is 0 wait states.
- Bypass register (last_addr, last_data, last_mask):
  - Loaded whenever wea ≠ 0.
  - On a DATA-cycle read, each byte lane i with last_mask[i]=1 and last_addr equal to the registered read word address takes last_data; all other lanes come from doutb.
  - last_mask is cleared when a later write to a different address loads the register, and on reset.
- HRDATA is the merged read data during a DATA read and 0 in every other cycle.
- Sub-word reads return the full 32-bit word; the master selects lanes.
- Reset: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wea=0, addra=0, dina=0, last_mask=0, address-phase registers=0.
- Reset asserted mid-transfer: any pending write is abandoned and no strobe is issued after reset.
- Address bits above ADDR_WIDTH+1 are ignored; the address wraps within the RAM.
- Back-to-back write followed by a read of the same word: the read returns the new data through the bypass, with zero wait states.

Decomposition:
- Shared package (ahb_pkg), also used by the matrix:
  - HTRANS encodings.
  - HSIZE encodings.
  - HRESP_OKAY / HRESP_ERROR.
  - A function mapping size and address LSBs to a byte mask.
- One sub-module, ahb_bram_bypass: bypass registers plus the lane-merge logic.
- The state machine and decode stay in the top level.

Test Plan:
- Word write 0xDEADBEEF to 0x100, then an idle cycle, then a read of 0x100 → wea=4'hF with addra=0x40; HRDATA=0xDEADBEEF; HREADYOUT=1 in all cycles.
- Byte writes 0x11 to 0x201 and 0x22 to 0x203 over a word preloaded with 0xAABBCCDD, then a read of 0x200 → wea=4'b0010 then 4'b1000; HRDATA=0x22BB11DD.
- Back-to-back pipelined write 0x12345678 to 0x300 and read of 0x300 → HRDATA=0x12345678 in the cycle immediately after the write data phase, via the bypass.
- Half-word write to 0x401 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); wea stays 0; a subsequent read of 0x400 returns the original data.
- HSIZE=3 read → two-cycle ERROR; HSEL=0 or HTRANS=IDLE traffic → HREADYOUT=1, HRESP=0, wea=0.
- HRESET pulsed during the data phase of a write → wea=0 from reset onward; memory unchanged; all outputs at their reset values.
